// File: rtl/dmem_pkg.sv
// Shared types, size encodings and request legality check for the data-memory arbiter.
package dmem_pkg;

   localparam int unsigned SIZE_BITS = 3;

   localparam logic [SIZE_BITS-1:0] SIZE_B = 3'b001;
   localparam logic [SIZE_BITS-1:0] SIZE_H = 3'b010;
   localparam logic [SIZE_BITS-1:0] SIZE_W = 3'b100;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   // Latched control part of a request.
   typedef struct packed {
      logic                 we;
      logic                 sign;
      logic [SIZE_BITS-1:0] size;
   } ctl_t;

   // A request is legal when size is one-hot and the address is aligned to it.
   function automatic logic is_legal(input logic [SIZE_BITS-1:0] size, input logic [1:0] lo);
      logic ok;
      case (size)
         SIZE_B:  ok = 1'b1;
         SIZE_H:  ok = ~lo[0];
         SIZE_W:  ok = (lo == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request fields plus completion response.
interface dmem_arbiter_if
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 32
);
   logic                 req;
   logic                 we;
   logic                 sign;
   logic [SIZE_BITS-1:0] size;
   logic [ADDR_W-1:0]    addr;
   logic [DATA_W-1:0]    wdata;
   logic                 ack;
   logic                 err;
   logic [DATA_W-1:0]    rdata;

   modport master (
      output req, we, sign, size, addr, wdata,
      input  ack, err, rdata
   );

   modport slave (
      input  req, we, sign, size, addr, wdata,
      output ack, err, rdata
   );
endinterface

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin against the last granted port, or port 0 wins when fixed_i.
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   input  logic       fixed_i,
   output logic [1:0] gnt_o
);

   // One-hot grant; on a tie the port that was not served last wins unless fixed.
   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = (fixed_i || last_i) ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the data memory: grant, one access, ack.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   dmem_arbiter_if.slave        m0,
   dmem_arbiter_if.slave        m1,
   output logic                 busy,
   output logic                 dm_ena,
   output logic                 dm_w,
   output logic                 dm_r,
   output logic                 dm_sign,
   output logic [SIZE_BITS-1:0] dm_size,
   output logic [ADDR_W-1:0]    dm_addr,
   output logic [DATA_W-1:0]    dm_wdata,
   input  logic [DATA_W-1:0]    dm_rdata
);

   localparam logic FIXED = 1'(FIXED_PRIO != 0);

   // Sequencer state and the latched request.
   state_e              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_q, last_d;
   ctl_t                ctl_q, ctl_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                err_q, err_d;

   // Registered outputs.
   logic                 busy_q, busy_d;
   logic                 dm_ena_q, dm_ena_d;
   logic                 dm_w_q, dm_w_d;
   logic                 dm_r_q, dm_r_d;
   logic                 dm_sign_q, dm_sign_d;
   logic [SIZE_BITS-1:0] dm_size_q, dm_size_d;
   logic [ADDR_W-1:0]    dm_addr_q, dm_addr_d;
   logic [DATA_W-1:0]    dm_wdata_q, dm_wdata_d;
   logic [1:0]           ack_q, ack_d;
   logic [1:0]           rsp_err_q, rsp_err_d;
   logic [1:0]           rd_sel_q, rd_sel_d;

   logic [1:0]           gnt;
   ctl_t                 sel_ctl;
   logic [ADDR_W-1:0]    sel_addr;
   logic [DATA_W-1:0]    sel_wdata;

   rr_arb2 u_arb (
      .req_i   ({m1.req, m0.req}),
      .last_i  (last_q),
      .fixed_i (FIXED),
      .gnt_o   (gnt)
   );

   // Fields of the port being granted this cycle.
   always_comb begin
      sel_ctl   = '{we: m0.we, sign: m0.sign, size: m0.size};
      sel_addr  = m0.addr;
      sel_wdata = m0.wdata;
      if (gnt[1]) begin
         sel_ctl   = '{we: m1.we, sign: m1.sign, size: m1.size};
         sel_addr  = m1.addr;
         sel_wdata = m1.wdata;
      end
   end

   // Next state, latched request and next values of the registered outputs.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      ctl_d      = ctl_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      busy_d     = 1'b0;
      dm_ena_d   = 1'b0;
      dm_w_d     = 1'b0;
      dm_r_d     = 1'b0;
      dm_sign_d  = 1'b0;
      dm_size_d  = '0;
      dm_addr_d  = '0;
      dm_wdata_d = '0;
      ack_d      = 2'b00;
      rsp_err_d  = 2'b00;
      rd_sel_d   = 2'b00;

      case (state_q)
         IDLE: begin
            if (gnt != 2'b00) begin
               owner_d = gnt[1];
               ctl_d   = sel_ctl;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               err_d   = ~is_legal(sel_ctl.size, sel_addr[1:0]);
               state_d = err_d ? DONE : ACCESS;
            end
         end
         ACCESS: state_d = DONE;
         DONE: begin
            last_d  = owner_q;
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered against the state being entered.
      busy_d = (state_d != IDLE);
      if (state_d == ACCESS) begin
         dm_ena_d   = 1'b1;
         dm_w_d     = ctl_d.we;
         dm_r_d     = ~ctl_d.we;
         dm_sign_d  = ctl_d.sign;
         dm_size_d  = ctl_d.size;
         dm_addr_d  = addr_d;
         dm_wdata_d = wdata_d;
      end
      if (state_d == DONE) begin
         ack_d[owner_d]     = 1'b1;
         rsp_err_d[owner_d] = err_d;
         rd_sel_d[owner_d]  = ~ctl_d.we & ~err_d;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         last_q     <= 1'b1;
         ctl_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         dm_ena_q   <= 1'b0;
         dm_w_q     <= 1'b0;
         dm_r_q     <= 1'b0;
         dm_sign_q  <= 1'b0;
         dm_size_q  <= '0;
         dm_addr_q  <= '0;
         dm_wdata_q <= '0;
         ack_q      <= 2'b00;
         rsp_err_q  <= 2'b00;
         rd_sel_q   <= 2'b00;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         ctl_q      <= ctl_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         dm_ena_q   <= dm_ena_d;
         dm_w_q     <= dm_w_d;
         dm_r_q     <= dm_r_d;
         dm_sign_q  <= dm_sign_d;
         dm_size_q  <= dm_size_d;
         dm_addr_q  <= dm_addr_d;
         dm_wdata_q <= dm_wdata_d;
         ack_q      <= ack_d;
         rsp_err_q  <= rsp_err_d;
         rd_sel_q   <= rd_sel_d;
      end
   end

   assign busy     = busy_q;
   assign dm_ena   = dm_ena_q;
   assign dm_w     = dm_w_q;
   assign dm_r     = dm_r_q;
   assign dm_sign  = dm_sign_q;
   assign dm_size  = dm_size_q;
   assign dm_addr  = dm_addr_q;
   assign dm_wdata = dm_wdata_q;

   // Memory read data is only valid in DONE, so it is steered by a registered select.
   assign m0.ack   = ack_q[0];
   assign m0.err   = rsp_err_q[0];
   assign m0.rdata = rd_sel_q[0] ? dm_rdata : '0;
   assign m1.ack   = ack_q[1];
   assign m1.err   = rsp_err_q[1];
   assign m1.rdata = rd_sel_q[1] ? dm_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance 0 round-robin, instance 1 fixed priority, each with a memory.
`timescale 1ns/1ps
module tb_dmem_arbiter;
   import dmem_pkg::*;

   localparam int unsigned AW = 12;
   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Stimulus per instance k and port p.
   logic          rst_v   [2];
   logic          req_v   [2][2];
   logic          we_v    [2][2];
   logic          sign_v  [2][2];
   logic [2:0]    size_v  [2][2];
   logic [AW-1:0] addr_v  [2][2];
   logic [DW-1:0] wdata_v [2][2];

   wire           ack_w     [2][2];
   wire           err_w     [2][2];
   wire [DW-1:0]  rdata_w   [2][2];
   wire           busy_w    [2];
   wire           ena_w     [2];
   wire [50:0]    dmbus_w   [2];
   wire [31:0]    ena_cnt_w [2];

   // Word-lane memory device: byte/half/word writes and sign-controlled reads.
   function automatic logic [31:0] mem_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [2:0] sz, input logic [1:0] lo);
      logic [31:0] r;
      r = old;
      case (sz)
         SIZE_B:  r[int'(lo)*8 +: 8] = wd[7:0];
         SIZE_H:  r[int'(lo[1])*16 +: 16] = wd[15:0];
         default: r = wd;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] mem_extract(input logic [31:0] w, input logic [2:0] sz,
                                               input logic sg, input logic [1:0] lo);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = w[int'(lo)*8 +: 8];
      h = w[int'(lo[1])*16 +: 16];
      case (sz)
         SIZE_B:  r = sg ? {{24{b[7]}}, b} : {24'h0, b};
         SIZE_H:  r = sg ? {{16{h[15]}}, h} : {16'h0, h};
         default: r = w;
      endcase
      return r;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0 ();
      dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1 ();
      logic          busy, dm_ena, dm_w, dm_r, dm_sign;
      logic [2:0]    dm_size;
      logic [AW-1:0] dm_addr;
      logic [DW-1:0] dm_wdata;
      logic [DW-1:0] dm_rdata = '0;
      logic [31:0]   mem [1024];
      int            ena_cnt = 0;

      assign m0.req   = req_v[g][0];
      assign m0.we    = we_v[g][0];
      assign m0.sign  = sign_v[g][0];
      assign m0.size  = size_v[g][0];
      assign m0.addr  = addr_v[g][0];
      assign m0.wdata = wdata_v[g][0];
      assign m1.req   = req_v[g][1];
      assign m1.we    = we_v[g][1];
      assign m1.sign  = sign_v[g][1];
      assign m1.size  = size_v[g][1];
      assign m1.addr  = addr_v[g][1];
      assign m1.wdata = wdata_v[g][1];

      assign ack_w[g][0]   = m0.ack;
      assign err_w[g][0]   = m0.err;
      assign rdata_w[g][0] = m0.rdata;
      assign ack_w[g][1]   = m1.ack;
      assign err_w[g][1]   = m1.err;
      assign rdata_w[g][1] = m1.rdata;
      assign busy_w[g]     = busy;
      assign ena_w[g]      = dm_ena;
      assign dmbus_w[g]    = {dm_ena, dm_w, dm_r, dm_sign, dm_size, dm_addr, dm_wdata};
      assign ena_cnt_w[g]  = 32'(ena_cnt);

      dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(g)) u_dut (
         .clk      (clk),
         .rst      (rst_v[g]),
         .m0       (m0),
         .m1       (m1),
         .busy     (busy),
         .dm_ena   (dm_ena),
         .dm_w     (dm_w),
         .dm_r     (dm_r),
         .dm_sign  (dm_sign),
         .dm_size  (dm_size),
         .dm_addr  (dm_addr),
         .dm_wdata (dm_wdata),
         .dm_rdata (dm_rdata)
      );

      initial begin
         for (int i = 0; i < 1024; i++) mem[i] = '0;
      end

      always @(posedge clk) begin
         if (dm_ena) begin
            ena_cnt <= ena_cnt + 1;
            if (dm_w) mem[dm_addr[AW-1:2]] <= mem_merge(mem[dm_addr[AW-1:2]], dm_wdata, dm_size, dm_addr[1:0]);
            else      dm_rdata <= mem_extract(mem[dm_addr[AW-1:2]], dm_size, dm_sign, dm_addr[1:0]);
         end
      end
   end

   // Reference: flat byte array per instance, transactions applied in completion order.
   logic [7:0] ref_mem [2][4096];

   function automatic int nbytes(input logic [2:0] sz);
      case (sz)
         3'b001:  return 1;
         3'b010:  return 2;
         3'b100:  return 4;
         default: return 0;
      endcase
   endfunction

   task automatic model_apply(input int k, input logic we, input logic sg, input logic [2:0] sz,
                              input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              output logic exp_err, output logic [DW-1:0] exp_rd);
      int n;
      logic [31:0] v;
      n = nbytes(sz);
      v = '0;
      exp_rd = '0;
      exp_err = !(n != 0 && (int'(a) % n) == 0);
      if (!exp_err) begin
         if (we) begin
            for (int i = 0; i < n; i++) ref_mem[k][int'(a) + i] = wd[8*i +: 8];
         end else begin
            for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[k][int'(a) + i];
            if (sg && n < 4 && v[8*n-1]) for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
            exp_rd = v;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input int p, input logic r, input logic we, input logic sg,
                          input logic [2:0] sz, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      req_v[k][p]   = r;
      we_v[k][p]    = we;
      sign_v[k][p]  = sg;
      size_v[k][p]  = sz;
      addr_v[k][p]  = a;
      wdata_v[k][p] = wd;
   endtask

   task automatic do_reset(input int k);
      rst_v[k] = 1'b1;
      for (int p = 0; p < 2; p++) req_v[k][p] = 1'b0;
      tick();
      tick();
      rst_v[k] = 1'b0;
   endtask

   task automatic rand_fields(output logic we, output logic sg, output logic [2:0] sz,
                              output logic [AW-1:0] a, output logic [DW-1:0] wd);
      int r;
      r  = int'($urandom_range(0, 9));
      we = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      wd = $urandom();
      a  = AW'(32'h100 + $urandom_range(0, 63));
      if (r < 3) sz = SIZE_B;
      else if (r < 6) begin
         sz = SIZE_H;
         if ($urandom_range(0, 7) != 0) a[0] = 1'b0;
      end else if (r < 9) begin
         sz = SIZE_W;
         if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      end else sz = 3'b011;
   endtask

   task automatic new_txn(input int k, input int p);
      logic we, sg;
      logic [2:0] sz;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      rand_fields(we, sg, sz, a, wd);
      set_req(k, p, 1'b1, we, sg, sz, a, wd);
   endtask

   // One transaction on an idle instance: latency, response and memory-enable count.
   task automatic do_txn(input int k, input int p, input logic we, input logic sg, input logic [2:0] sz,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd, output logic [DW-1:0] rd);
      int lat;
      int e0;
      logic xe;
      logic [DW-1:0] xr;
      e0 = int'(ena_cnt_w[k]);
      set_req(k, p, 1'b1, we, sg, sz, a, wd);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!ack_w[k][p] && lat < 8);
      model_apply(k, we, sg, sz, a, wd, xe, xr);
      chk("ack_latency", 64'(lat), xe ? 64'd1 : 64'd2);
      chk("ack", 64'(ack_w[k][p]), 64'd1);
      chk("other_ack", 64'(ack_w[k][1-p]), 64'd0);
      chk("err", 64'(err_w[k][p]), 64'(xe));
      chk("rdata", 64'(rdata_w[k][p]), 64'(xr));
      chk("mem_enables", 64'(int'(ena_cnt_w[k]) - e0), xe ? 64'd0 : 64'd1);
      rd = rdata_w[k][p];
      req_v[k][p] = 1'b0;
      tick();
   endtask

   // Both ports hold requests for 4 transactions each; grant order follows the arbitration rule.
   task automatic run_pair(input int k);
      int done [2];
      int c [2];
      int exp_order [$];
      int last, g, idx, cyc;
      logic xe;
      logic [DW-1:0] xr;
      c[0] = 4;
      c[1] = 4;
      last = 1;
      while (c[0] + c[1] > 0) begin
         if (c[0] > 0 && c[1] > 0) g = (k == 1) ? 0 : 1 - last;
         else g = (c[0] > 0) ? 0 : 1;
         exp_order.push_back(g);
         c[g]--;
         last = g;
      end
      done[0] = 0;
      done[1] = 0;
      idx = 0;
      cyc = 0;
      new_txn(k, 0);
      new_txn(k, 1);
      while ((done[0] < 4 || done[1] < 4) && cyc < 100) begin
         tick();
         cyc++;
         for (int p = 0; p < 2; p++) begin
            if (ack_w[k][p]) begin
               chk("grant_order", 64'(p), 64'(exp_order[idx]));
               chk("pair_other_ack", 64'(ack_w[k][1-p]), 64'd0);
               model_apply(k, we_v[k][p], sign_v[k][p], size_v[k][p], addr_v[k][p], wdata_v[k][p], xe, xr);
               chk("pair_err", 64'(err_w[k][p]), 64'(xe));
               chk("pair_rdata", 64'(rdata_w[k][p]), 64'(xr));
               done[p]++;
               idx++;
               if (done[p] < 4) new_txn(k, p);
               else req_v[k][p] = 1'b0;
            end
         end
      end
      chk("pair_complete", 64'(done[0] + done[1]), 64'd8);
      req_v[k][0] = 1'b0;
      req_v[k][1] = 1'b0;
      tick();
   endtask

   task automatic chk_quiet(input int k, input string tag);
      chk({tag, "_busy"}, 64'(busy_w[k]), 64'd0);
      chk({tag, "_dm"}, 64'(dmbus_w[k]), 64'd0);
      for (int p = 0; p < 2; p++) begin
         chk({tag, "_ack"}, 64'(ack_w[k][p]), 64'd0);
         chk({tag, "_err"}, 64'(err_w[k][p]), 64'd0);
         chk({tag, "_rdata"}, 64'(rdata_w[k][p]), 64'd0);
      end
   endtask

   initial begin
      logic [DW-1:0] rd;
      logic we, sg, xe;
      logic [2:0] sz;
      logic [AW-1:0] a;
      logic [DW-1:0] wd, xr;
      int e0;

      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4096; i++) ref_mem[k][i] = 8'h00;
         rst_v[k] = 1'b1;
         for (int p = 0; p < 2; p++) set_req(k, p, 1'b0, 1'b0, 1'b0, 3'b000, '0, '0);
      end
      tick();
      tick();
      chk_quiet(0, "reset_rr");
      chk_quiet(1, "reset_fp");
      rst_v[0] = 1'b0;
      rst_v[1] = 1'b0;

      // Word store then load on port 0.
      do_txn(0, 0, 1'b1, 1'b0, SIZE_W, 12'h010, 32'hDEADBEEF, rd);
      do_txn(0, 0, 1'b0, 1'b0, SIZE_W, 12'h010, 32'h0, rd);
      chk("word_load", 64'(rd), 64'hDEADBEEF);

      // Byte and half loads on port 1.
      do_txn(0, 1, 1'b1, 1'b0, SIZE_W, 12'h020, 32'h80F07F01, rd);
      do_txn(0, 1, 1'b0, 1'b1, SIZE_B, 12'h023, 32'h0, rd);
      chk("lb_signed", 64'(rd), 64'hFFFFFF80);
      do_txn(0, 1, 1'b0, 1'b0, SIZE_B, 12'h022, 32'h0, rd);
      chk("lb_unsigned", 64'(rd), 64'h000000F0);
      do_txn(0, 1, 1'b0, 1'b1, SIZE_H, 12'h020, 32'h0, rd);
      chk("lh_signed", 64'(rd), 64'h00007F01);

      // Misaligned half and illegal size both complete early with err and no memory access.
      do_txn(0, 1, 1'b0, 1'b1, SIZE_H, 12'h021, 32'h0, rd);
      do_txn(0, 0, 1'b0, 1'b0, 3'b011, 12'h040, 32'h0, rd);
      do_txn(0, 0, 1'b1, 1'b0, SIZE_W, 12'h042, 32'h12345678, rd);

      // Reset while a store is in ACCESS: the memory saw that cycle's enable, so the write landed.
      do_txn(0, 0, 1'b1, 1'b0, SIZE_W, 12'h030, 32'h11111111, rd);
      set_req(0, 0, 1'b1, 1'b1, 1'b0, SIZE_W, 12'h030, 32'h22222222);
      tick();
      chk("access_ena", 64'(ena_w[0]), 64'd1);
      rst_v[0] = 1'b1;
      tick();
      chk_quiet(0, "rst_access");
      rst_v[0] = 1'b0;
      req_v[0][0] = 1'b0;
      model_apply(0, 1'b1, 1'b0, SIZE_W, 12'h030, 32'h22222222, xe, xr);
      tick();
      chk("rst_no_late_ack", 64'(ack_w[0][0]), 64'd0);
      do_txn(0, 0, 1'b0, 1'b0, SIZE_W, 12'h030, 32'h0, rd);
      chk("load_after_rst_access", 64'(rd), 64'h22222222);

      // Reset in the cycle the store would be granted: it never commits, old data stays.
      e0 = int'(ena_cnt_w[0]);
      set_req(0, 0, 1'b1, 1'b1, 1'b0, SIZE_W, 12'h030, 32'h33333333);
      rst_v[0] = 1'b1;
      tick();
      chk_quiet(0, "rst_idle");
      rst_v[0] = 1'b0;
      req_v[0][0] = 1'b0;
      tick();
      chk("rst_idle_no_enable", 64'(int'(ena_cnt_w[0]) - e0), 64'd0);
      do_txn(0, 0, 1'b0, 1'b0, SIZE_W, 12'h030, 32'h0, rd);
      chk("load_old_contents", 64'(rd), 64'h22222222);

      // Random single transactions on both instances.
      for (int n = 0; n < 24; n++) begin
         rand_fields(we, sg, sz, a, wd);
         do_txn(n % 2, int'($urandom_range(0, 1)), we, sg, sz, a, wd, rd);
      end

      // Concurrent held requests: alternate for round-robin, port 0 first for fixed priority.
      do_reset(0);
      run_pair(0);
      do_reset(1);
      run_pair(1);
      run_pair(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
